set_assoc_cache_ctrl: RTL

- Parametrised two-way set-associative read cache sitting between the ARM MEM stage and the SRAM controller.
- Generalises set count, line size and tag width.
- Write policy: write-through, no write-allocate; a write hit updates the cached word instead of invalidating the line.
- Adds an explicit request/ready FSM toward SRAM and a whole-cache flush sequencer.

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_way.sv | 55 +++++
 rtl/set_assoc_cache_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the two-way set-associative read cache.
// Latency: none (package). Backpressure: n/a.
package cache_pkg;
    typedef enum logic [1:0] {IDLE, MISS, WRITE, FLUSH} state_t;

    localparam int DEF_SETS       = 64;
    localparam int DEF_LINE_WORDS = 2;
    localparam int DEF_TAG_W      = 10;

    function automatic int off_w(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction
endpackage

// File: rtl/cache_way.sv
// One cache way: tag/valid/data arrays with combinational lookup and fill/update/clear ports.
// Latency: lookup is combinational, writes land on the next edge. Backpressure: none, always accepts.
// Only valid bits are reset; tag and data contents are don't-care until filled.
module cache_way
    import cache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAG_W      = DEF_TAG_W,
    localparam int IDX_W     = idx_w(SETS),
    localparam int WSEL_W    = $clog2(LINE_WORDS),
    localparam int LINE_W    = 32 * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    input  logic [WSEL_W-1:0] wsel,
    output logic              hit,
    output logic              vld,
    output logic [31:0]       word,
    input  logic              fill,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              upd,
    input  logic [31:0]       upd_data,
    input  logic              clr,
    input  logic [IDX_W-1:0]  clr_idx
);
    logic [TAG_W-1:0]  tags  [SETS];
    logic [LINE_W-1:0] lines [SETS];
    logic [SETS-1:0]   valid;

    assign vld  = valid[idx];
    assign hit  = vld && (tags[idx] == tag);
    assign word = lines[idx][{wsel, 5'd0} +: 32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clr) begin
            valid[clr_idx] <= 1'b0;
        end else if (fill) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tags[idx]  <= tag;
            lines[idx] <= fill_line;
        end else if (upd) begin
            lines[idx][{wsel, 5'd0} +: 32] <= upd_data;
        end
    end
endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// Two-way set-associative write-through read cache between the MEM stage and the SRAM controller.
// Latency: read hit 0 wait cycles, read miss >= 2 cycles (SRAM dependent), write waits for SRAM.
// Backpressure: requester holds rdEn/wrEn/address until the ready pulse; flush busies the cache for SETS cycles.
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAG_W      = DEF_TAG_W,
    localparam int LINE_W    = 32 * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdEn,
    input  logic              wrEn,
    input  logic              flush,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    input  logic              sramReady,
    input  logic [LINE_W-1:0] sramReadData,
    output logic              sramRdEn,
    output logic              sramWrEn,
    output logic              ready,
    output logic [31:0]       readData,
    output logic              flushDone
);
    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int WSEL_W = OFF_W - 2;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [SETS-1:0]    lru;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [WSEL_W-1:0]  wsel;
    logic               hit0, hit1, vld0, vld1, hit, victim;
    logic [31:0]        word0, word1, hit_word, fill_word;
    logic               fill_ev, unused_addr;

    assign idx         = address[OFF_W +: IDX_W];
    assign tag         = address[OFF_W + IDX_W +: TAG_W];
    assign wsel        = address[2 +: WSEL_W];
    assign unused_addr = ^{address[ADDR_W-1:OFF_W+IDX_W+TAG_W], address[1:0]};

    assign hit       = hit0 | hit1;
    assign hit_word  = hit0 ? word0 : word1;
    assign fill_word = sramReadData[{wsel, 5'd0} +: 32];
    // Prefer an empty way before evicting the LRU-designated one.
    assign victim    = !vld0 ? 1'b0 : (!vld1 ? 1'b1 : lru[idx]);
    assign fill_ev   = (state == MISS) && sramReady;

    cache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way0 (
        .clk(clk), .rst(rst), .idx(idx), .tag(tag), .wsel(wsel),
        .hit(hit0), .vld(vld0), .word(word0),
        .fill(fill_ev && !victim), .fill_line(sramReadData),
        .upd((state == IDLE) && wrEn && hit0), .upd_data(writeData),
        .clr(state == FLUSH), .clr_idx(cnt)
    );

    cache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way1 (
        .clk(clk), .rst(rst), .idx(idx), .tag(tag), .wsel(wsel),
        .hit(hit1), .vld(vld1), .word(word1),
        .fill(fill_ev && victim), .fill_line(sramReadData),
        .upd((state == IDLE) && wrEn && hit1), .upd_data(writeData),
        .clr(state == FLUSH), .clr_idx(cnt)
    );

    always_comb begin
        ready    = 1'b0;
        readData = '0;
        case (state)
            IDLE: if (!wrEn && rdEn && hit) begin
                ready    = 1'b1;
                readData = hit_word;
            end
            MISS: if (sramReady) begin
                ready    = 1'b1;
                readData = rdEn ? fill_word : '0;
            end
            WRITE: if (sramReady) ready = 1'b1;
            default: ;
        endcase
    end

    // LRU bit names the next victim, so a touched way makes the other way the victim.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru <= '0;
        end else begin
            case (state)
                IDLE:    if ((wrEn || rdEn) && hit) lru[idx] <= hit0;
                MISS:    if (sramReady) lru[idx] <= ~victim;
                FLUSH:   lru[cnt] <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sramRdEn  <= 1'b0;
            sramWrEn  <= 1'b0;
            flushDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrEn) begin
                        state    <= WRITE;
                        sramWrEn <= 1'b1;
                    end else if (rdEn) begin
                        if (!hit) begin
                            state    <= MISS;
                            sramRdEn <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end
                end
                MISS: if (sramReady) begin
                    state    <= IDLE;
                    sramRdEn <= 1'b0;
                end
                WRITE: if (sramReady) begin
                    state    <= IDLE;
                    sramWrEn <= 1'b0;
                end
                FLUSH: begin
                    if (cnt == IDX_W'(SETS - 1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        flushDone <= 1'b0;
                    end else begin
                        cnt       <= cnt + IDX_W'(1);
                        flushDone <= (cnt == IDX_W'(SETS - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
